// File: rtl/cart_ram_pkg.sv
// cart_ram_pkg
//   Shared types and constants for the cart-RAM arbiter.
//   state_t  : arbiter FSM states
//   src_t    : request sources, listed in grant priority order
//   req_t    : one pending request {valid, we, addr, data}
//   CRAM_AW  : width of the address field held in a pending request
package cart_ram_pkg;

    localparam int CRAM_AW = 17;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        BK_HI
    } state_t;

    typedef enum logic [1:0] {
        SRC_MAP,
        SRC_CPU,
        SRC_BK
    } src_t;

    // data is 16 bits so a backup word fits; CPU/mapper use data[7:0].
    // For backup requests addr holds the byte-0 address {bk_addr, 1'b0}.
    typedef struct packed {
        logic               valid;
        logic               we;
        logic [CRAM_AW-1:0] addr;
        logic [15:0]        data;
    } req_t;

    localparam logic [7:0]  CPU_DO_RST = 8'hFF;
    localparam logic [15:0] BK_DO_RST  = 16'hFFFF;

endpackage

// File: rtl/cart_ram_slot.sv
// cart_ram_slot
//   One pending-request slot for a single source of the arbiter.
//   Captures a request on strobe, overwrites a not-yet-issued request,
//   never touches an issued one, and clears on completion.
// Ports:
//   clk_sys, reset : clock, async active-high reset
//   strobe         : source strobe, req_in is captured on it
//   req_in         : request to capture (valid bit set by the caller)
//   issue          : the arbiter has granted this slot this cycle
//   done           : the granted access completes this cycle
//   slot           : current slot contents
//   overrun        : sticky, a strobe hit an occupied slot
module cart_ram_slot
    import cart_ram_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic strobe,
    input  req_t req_in,
    input  logic issue,
    input  logic done,
    output req_t slot,
    output logic overrun
);

    logic issued;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            slot    <= '0;
            issued  <= 1'b0;
            overrun <= 1'b0;
        end else if (done) begin
            // A strobe landing on the completion cycle fills the freed slot.
            if (strobe) slot <= req_in;
            else        slot <= '0;
            issued <= 1'b0;
        end else begin
            if (issue) issued <= 1'b1;
            if (strobe) begin
                if (!slot.valid) begin
                    slot <= req_in;
                end else begin
                    overrun <= 1'b1;
                    // On the grant cycle the old contents are already being
                    // latched into the memory port, so the new strobe is dropped.
                    if (!issued && !issue) slot <= req_in;
                end
            end
        end
    end

endmodule

// File: rtl/cart_ram_arbiter.sv
// cart_ram_arbiter
//   Serialises mapper direct writes, CPU cart-RAM accesses and backup-RAM
//   word accesses onto one byte-wide req/ack memory port.
//   Priority map > cpu > bk; a backup word is two consecutive byte accesses
//   (little-endian) that cannot be split by other sources.
// Optional feature: define CART_RAM_TIMEOUT_EN to abort an access after
//   TIMEOUT cycles without mem_ack (read data 8'hFF) and flag timeout_err.
// Ports:
//   clk_sys, reset                      clock, async active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_di       CPU strobes, address, write data
//   cpu_do, cpu_busy                    held read data, CPU request pending
//   map_wr/map_addr/map_di              mapper direct write
//   bk_rd/bk_wr/bk_addr/bk_di           backup word access
//   bk_do, bk_ack                       held backup word, completion pulse
//   mem_req/mem_we/mem_addr/mem_d       memory request (held until ack)
//   mem_q, mem_ack                      memory read data, completion pulse
//   overrun                             sticky source overrun
//   timeout_err                         sticky timeout (optional)
module cart_ram_arbiter
    import cart_ram_pkg::*;
#(
    parameter int AW = 17
`ifdef CART_RAM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_di,
    output logic [7:0]    cpu_do,
    output logic          cpu_busy,
    input  logic          map_wr,
    input  logic [AW-1:0] map_addr,
    input  logic [7:0]    map_di,
    input  logic          bk_rd,
    input  logic          bk_wr,
    input  logic [AW-2:0] bk_addr,
    input  logic [15:0]   bk_di,
    output logic [15:0]   bk_do,
    output logic          bk_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_d,
    input  logic [7:0]    mem_q,
    input  logic          mem_ack,
    output logic          overrun
`ifdef CART_RAM_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    // state | meaning
    // IDLE  | no access in flight; grants the highest-priority valid slot
    // BUSY  | single byte access (or backup byte 0) waiting for ack
    // BK_HI | backup byte 1; raised without re-arbitration, waits for ack

    state_t state, state_next;
    src_t   cur_src, sel;
    req_t   map_in, cpu_in, bk_in;
    req_t   map_q, cpu_q, bk_q, sel_req;
    logic   ovr_map, ovr_cpu, ovr_bk;
    logic   grant, load_hi, load_en;
    logic   issue_map, issue_cpu, issue_bk;
    logic   done_map, done_cpu, done_bk;
    logic   ack_eff, tmo_hit;
    logic [7:0]    q_eff;
    logic [AW-1:0] nxt_addr;
    logic [7:0]    nxt_d;

    always_comb begin
        map_in.valid = 1'b1;
        map_in.we    = 1'b1;
        map_in.addr  = CRAM_AW'(map_addr);
        map_in.data  = {8'h00, map_di};

        cpu_in.valid = 1'b1;
        cpu_in.we    = cpu_wr;
        cpu_in.addr  = CRAM_AW'(cpu_addr);
        cpu_in.data  = {8'h00, cpu_di};

        bk_in.valid  = 1'b1;
        bk_in.we     = bk_wr;
        bk_in.addr   = CRAM_AW'({bk_addr, 1'b0});
        bk_in.data   = bk_di;
    end

    cart_ram_slot u_slot_map (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (map_wr),
        .req_in  (map_in),
        .issue   (issue_map),
        .done    (done_map),
        .slot    (map_q),
        .overrun (ovr_map)
    );

    cart_ram_slot u_slot_cpu (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (cpu_rd | cpu_wr),
        .req_in  (cpu_in),
        .issue   (issue_cpu),
        .done    (done_cpu),
        .slot    (cpu_q),
        .overrun (ovr_cpu)
    );

    cart_ram_slot u_slot_bk (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (bk_rd | bk_wr),
        .req_in  (bk_in),
        .issue   (issue_bk),
        .done    (done_bk),
        .slot    (bk_q),
        .overrun (ovr_bk)
    );

    assign overrun  = ovr_map | ovr_cpu | ovr_bk;
    assign cpu_busy = cpu_q.valid;  // slot stays valid until its access completes

`ifdef CART_RAM_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;

    assign tmo_hit = mem_req && (tmo_cnt == 8'd0);
    assign q_eff   = (tmo_hit && !mem_ack) ? 8'hFF : mem_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (load_en)
                tmo_cnt <= TMO_LOAD;
            else if (mem_req && tmo_cnt != 8'd0)
                tmo_cnt <= tmo_cnt - 8'd1;
            if (tmo_hit && !mem_ack)
                timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign q_eff   = mem_q;
`endif

    // A stray ack while no request is raised is ignored.
    assign ack_eff = mem_req && (mem_ack || tmo_hit);

    always_comb begin
        state_next = state;
        sel        = SRC_MAP;
        if (state == BK_HI)   sel = SRC_BK;
        else if (map_q.valid) sel = SRC_MAP;
        else if (cpu_q.valid) sel = SRC_CPU;
        else if (bk_q.valid)  sel = SRC_BK;

        sel_req = map_q;
        case (sel)
            SRC_MAP: sel_req = map_q;
            SRC_CPU: sel_req = cpu_q;
            default: sel_req = bk_q;
        endcase

        grant    = (state == IDLE) && sel_req.valid;
        load_hi  = (state == BK_HI) && !mem_req && sel_req.valid;
        load_en  = grant || load_hi;
        nxt_addr = load_hi ? AW'({sel_req.addr[CRAM_AW-1:1], 1'b1}) : AW'(sel_req.addr);
        nxt_d    = load_hi ? sel_req.data[15:8] : sel_req.data[7:0];

        issue_map = grant && (sel == SRC_MAP);
        issue_cpu = grant && (sel == SRC_CPU);
        issue_bk  = grant && (sel == SRC_BK);
        done_map  = ack_eff && (state == BUSY) && (cur_src == SRC_MAP);
        done_cpu  = ack_eff && (state == BUSY) && (cur_src == SRC_CPU);
        done_bk   = ack_eff && (state == BK_HI);

        case (state)
            IDLE:    if (grant) state_next = BUSY;
            BUSY:    if (ack_eff) state_next = (cur_src == SRC_BK) ? BK_HI : IDLE;
            BK_HI:   if (ack_eff) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cur_src  <= SRC_MAP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_d    <= 8'h00;
            cpu_do   <= CPU_DO_RST;
            bk_do    <= BK_DO_RST;
            bk_ack   <= 1'b0;
        end else begin
            bk_ack <= 1'b0;
            if (load_en) begin
                if (grant) cur_src <= sel;
                mem_req  <= 1'b1;
                mem_we   <= sel_req.we;
                mem_addr <= nxt_addr;
                mem_d    <= nxt_d;
            end
            if (ack_eff) begin
                mem_req <= 1'b0;
                if (state == BUSY) begin
                    if (cur_src == SRC_CPU && !mem_we) cpu_do      <= q_eff;
                    if (cur_src == SRC_BK  && !mem_we) bk_do[7:0]  <= q_eff;
                end else if (state == BK_HI) begin
                    if (!mem_we) bk_do[15:8] <= q_eff;
                    bk_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_ram_arbiter.sv
module tb_cart_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_di, cpu_do;
    logic        cpu_busy;
    logic        map_wr;
    logic [16:0] map_addr;
    logic [7:0]  map_di;
    logic        bk_rd, bk_wr;
    logic [15:0] bk_addr;
    logic [15:0] bk_di, bk_do;
    logic        bk_ack;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_d, mem_q;
    logic        mem_ack;
    logic        overrun;
`ifdef CART_RAM_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cart_ram_arbiter #(.AW(17)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_di   (cpu_di),
        .cpu_do   (cpu_do),
        .cpu_busy (cpu_busy),
        .map_wr   (map_wr),
        .map_addr (map_addr),
        .map_di   (map_di),
        .bk_rd    (bk_rd),
        .bk_wr    (bk_wr),
        .bk_addr  (bk_addr),
        .bk_di    (bk_di),
        .bk_do    (bk_do),
        .bk_ack   (bk_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_q    (mem_q),
        .mem_ack  (mem_ack),
        .overrun  (overrun)
`ifdef CART_RAM_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_di = '0;
        map_wr = 0; map_addr = '0; map_di = '0;
        bk_rd = 0; bk_wr = 0; bk_addr = '0; bk_di = '0;
        mem_q = '0; mem_ack = 0;

        // ---- reset state
        #12;
        chk("rst_cpu_do",   32'(cpu_do),   32'hFF);
        chk("rst_bk_do",    32'(bk_do),    32'hFFFF);
        chk("rst_mem_req",  32'(mem_req),  32'h0);
        chk("rst_cpu_busy", 32'(cpu_busy), 32'h0);
        chk("rst_overrun",  32'(overrun),  32'h0);
        chk("rst_bk_ack",   32'(bk_ack),   32'h0);
        reset = 1'b0;
        tick();

        // ---- CPU read, ack in 3rd request cycle
        cpu_rd = 1; cpu_addr = 17'h00123;
        tick(); cpu_rd = 0;
        chk("rd_req_lat1", 32'(mem_req),  32'h0);
        chk("rd_busy",     32'(cpu_busy), 32'h1);
        tick();
        chk("rd_req",  32'(mem_req),  32'h1);
        chk("rd_we",   32'(mem_we),   32'h0);
        chk("rd_addr", 32'(mem_addr), 32'h00123);
        tick(); tick();
        mem_ack = 1; mem_q = 8'h5A;
        tick(); mem_ack = 0; mem_q = 8'h00;
        chk("rd_cpu_do", 32'(cpu_do),   32'h5A);
        chk("rd_idle",   32'(cpu_busy), 32'h0);
        chk("rd_drop",   32'(mem_req),  32'h0);

        // ---- simultaneous map_wr and cpu_wr
        map_wr = 1; map_addr = 17'h00010; map_di = 8'hAA;
        cpu_wr = 1; cpu_addr = 17'h00020; cpu_di = 8'h55;
        tick(); map_wr = 0; cpu_wr = 0;
        tick();
        chk("pri_map_req",  32'(mem_req),  32'h1);
        chk("pri_map_we",   32'(mem_we),   32'h1);
        chk("pri_map_addr", 32'(mem_addr), 32'h00010);
        chk("pri_map_d",    32'(mem_d),    32'hAA);
        mem_ack = 1;
        tick(); mem_ack = 0;
        chk("pri_gap", 32'(mem_req), 32'h0);
        tick();
        chk("pri_cpu_req",  32'(mem_req),  32'h1);
        chk("pri_cpu_addr", 32'(mem_addr), 32'h00020);
        chk("pri_cpu_d",    32'(mem_d),    32'h55);
        mem_ack = 1;
        tick(); mem_ack = 0;
        chk("pri_cpu_done", 32'(cpu_busy), 32'h0);

        // ---- backup word write, map write arrives during byte 0
        bk_wr = 1; bk_addr = 16'h0004; bk_di = 16'hBEEF;
        tick(); bk_wr = 0;
        tick();
        chk("bk0_addr", 32'(mem_addr), 32'h00008);
        chk("bk0_d",    32'(mem_d),    32'hEF);
        chk("bk0_we",   32'(mem_we),   32'h1);
        map_wr = 1; map_addr = 17'h00030; map_di = 8'h11;
        tick(); map_wr = 0;
        mem_ack = 1;
        tick(); mem_ack = 0;
        chk("bk_gap", 32'(mem_req), 32'h0);
        tick();
        chk("bk1_req",  32'(mem_req),  32'h1);
        chk("bk1_addr", 32'(mem_addr), 32'h00009);
        chk("bk1_d",    32'(mem_d),    32'hBE);
        mem_ack = 1;
        tick(); mem_ack = 0;
        chk("bk_ack_pulse", 32'(bk_ack),  32'h1);
        chk("bk_no_ovr",    32'(overrun), 32'h0);
        tick();
        chk("bk_ack_clr",  32'(bk_ack),   32'h0);
        chk("bk_map_addr", 32'(mem_addr), 32'h00030);
        chk("bk_map_d",    32'(mem_d),    32'h11);
        mem_ack = 1;
        tick(); mem_ack = 0;

        // ---- backup word read
        bk_rd = 1; bk_addr = 16'h0005;
        tick(); bk_rd = 0;
        tick();
        chk("bkr0_addr", 32'(mem_addr), 32'h0000A);
        chk("bkr0_we",   32'(mem_we),   32'h0);
        mem_ack = 1; mem_q = 8'h34;
        tick(); mem_ack = 0; mem_q = 8'h00;
        chk("bkr_lo", 32'(bk_do), 32'hFF34);
        tick();
        chk("bkr1_addr", 32'(mem_addr), 32'h0000B);
        mem_ack = 1; mem_q = 8'h12;
        tick(); mem_ack = 0; mem_q = 8'h00;
        chk("bkr_word", 32'(bk_do),  32'h1234);
        chk("bkr_ack",  32'(bk_ack), 32'h1);

        // ---- strobe in the ack cycle refills the slot without overrun
        cpu_wr = 1; cpu_addr = 17'h00060; cpu_di = 8'h01;
        tick(); cpu_wr = 0;
        tick();
        chk("re_first", 32'(mem_addr), 32'h00060);
        mem_ack = 1;
        cpu_wr = 1; cpu_addr = 17'h00061; cpu_di = 8'h02;
        tick(); mem_ack = 0; cpu_wr = 0;
        chk("re_busy", 32'(cpu_busy), 32'h1);
        chk("re_ovr",  32'(overrun),  32'h0);
        tick();
        chk("re_addr", 32'(mem_addr), 32'h00061);
        chk("re_d",    32'(mem_d),    32'h02);
        mem_ack = 1;
        tick(); mem_ack = 0;

        // ---- overrun: two cpu_wr while a map write is in flight
        map_wr = 1; map_addr = 17'h00040; map_di = 8'h01;
        tick(); map_wr = 0;
        tick();
        chk("ov_map_addr", 32'(mem_addr), 32'h00040);
        cpu_wr = 1; cpu_addr = 17'h00050; cpu_di = 8'h77;
        tick();
        cpu_addr = 17'h00051; cpu_di = 8'h88;
        tick(); cpu_wr = 0;
        chk("ov_flag", 32'(overrun), 32'h1);
        mem_ack = 1;
        tick(); mem_ack = 0;
        tick();
        chk("ov_cpu_addr", 32'(mem_addr), 32'h00051);
        chk("ov_cpu_d",    32'(mem_d),    32'h88);
        mem_ack = 1;
        tick(); mem_ack = 0;
        tick();
        chk("ov_no_more", 32'(mem_req), 32'h0);

        // ---- reset during BUSY
        cpu_rd = 1; cpu_addr = 17'h00070;
        tick(); cpu_rd = 0;
        tick();
        chk("rb_req", 32'(mem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rb_req_drop", 32'(mem_req), 32'h0);
        chk("rb_cpu_do",   32'(cpu_do),  32'hFF);
        chk("rb_ovr",      32'(overrun), 32'h0);
        #2 reset = 1'b0;
        repeat (4) tick();
        chk("rb_no_spur", 32'(mem_req),  32'h0);
        chk("rb_busy",    32'(cpu_busy), 32'h0);

`ifdef CART_RAM_TIMEOUT_EN
        // ---- timeout: normal read first so cpu_do differs from 8'hFF
        cpu_rd = 1; cpu_addr = 17'h00081;
        tick(); cpu_rd = 0;
        tick();
        mem_ack = 1; mem_q = 8'h3C;
        tick(); mem_ack = 0; mem_q = 8'h00;
        chk("to_pre", 32'(cpu_do), 32'h3C);
        cpu_rd = 1; cpu_addr = 17'h00080;
        tick(); cpu_rd = 0;
        tick();
        repeat (62) tick();
        chk("to_c63_req", 32'(mem_req),     32'h1);
        chk("to_c63_err", 32'(timeout_err), 32'h0);
        tick();
        chk("to_c64_req", 32'(mem_req), 32'h1);
        tick();
        chk("to_req_drop", 32'(mem_req),     32'h0);
        chk("to_cpu_do",   32'(cpu_do),      32'hFF);
        chk("to_err",      32'(timeout_err), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cart_ram_arbiter.md
Name: cart_ram_arbiter

Overview:
- Downstream consumer of the mapper block's cart-RAM interface.
- Takes the mapper's translated cart-RAM address with CPU read/write strobes, mapper-initiated direct writes (MBC7 EEPROM, TAMA), and backup-RAM save/load word accesses.
- Serialises all of them onto one byte-wide req/ack memory port (SDRAM/BRAM controller).
- Returns read data to the CPU and to the backup path.

Parameters:
- AW, 17, cart-RAM byte address width (matches mapper cram_addr).
- TIMEOUT, 64, cycles without mem_ack before abort (only with the optional feature).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_rd  in  1  single-cycle CPU cart-RAM read strobe
- cpu_wr  in  1  single-cycle CPU cart-RAM write strobe
- cpu_addr  in  AW  mapper-translated byte address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  last CPU read data, held
- cpu_busy  out  1  CPU request pending or in flight
- map_wr  in  1  mapper direct-write strobe (cram_wr)
- map_addr  in  AW  mapper write address
- map_di  in  8  mapper write data (cram_wr_do)
- bk_rd  in  1  backup word read strobe
- bk_wr  in  1  backup word write strobe
- bk_addr  in  AW-1  backup word address
- bk_di  in  16  backup write word
- bk_do  out  16  backup read word, held
- bk_ack  out  1  one-cycle pulse when a backup word completes
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier, stable while mem_req
- mem_addr  out  AW  byte address, stable while mem_req
- mem_d  out  8  write data, stable while mem_req
- mem_q  in  8  read data, valid on the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- overrun  out  1  sticky; a source strobed while its previous request was still pending

Behaviour:
- Reset: all outputs 0 except cpu_do = 8'hFF and bk_do = 16'hFFFF. Pending slots cleared. FSM = IDLE.
- Pending slots:
  - Each source has one slot {valid, we, addr, data}, captured on its strobe.
  - A strobe on an occupied, not-yet-issued slot overwrites it and sets overrun. An issued request is never modified.
  - cpu_rd and cpu_wr asserted together: the write wins.
  - bk_rd and bk_wr asserted together: the write wins.
- Priority at grant: map > cpu > bk. Fixed, non-rotating.
- FSM states:
  - IDLE: if any slot valid, latch the winner into the mem_* registers, assert mem_req the next cycle, go to BUSY. Grant-to-mem_req latency is 1 cycle; strobe-to-mem_req minimum is 2 cycles.
  - BUSY: hold mem_* until mem_ack.
    - On ack, a CPU read loads cpu_do <= mem_q; then clear the slot and go to IDLE.
    - If the completed access is backup byte 0, go to BK_HI instead.
  - BK_HI: issue byte 1 (addr = {bk_addr,1'b1}) immediately, without re-arbitration. This keeps the word atomic; higher-priority requests wait.
    - On ack: bk_do[15:8] <= mem_q for reads, bk_ack pulses, slot cleared, go to IDLE.
- Backup byte order: byte 0 = {bk_addr,0} = bits [7:0]; byte 1 = {bk_addr,1} = bits [15:8] (little-endian).
- A strobe arriving in the same cycle as mem_ack for the same source is captured into the freed slot; it is not lost and does not set overrun.
- mem_req drops in the cycle after mem_ack. Back-to-back requests therefore have a 1-cycle gap.
- cpu_busy = cpu slot valid OR CPU access in flight.
- Reset mid-transaction: mem_req drops immediately (async). The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: CART_RAM_TIMEOUT_EN.
- When defined:
  - An 8-bit counter runs in BUSY/BK_HI.
  - After TIMEOUT cycles without mem_ack, the arbiter behaves as if ack arrived with mem_q = 8'hFF.
  - It also sets a sticky output port, timeout_err.
- When undefined: no counter, no timeout_err port, and the arbiter waits indefinitely.

Decomposition:
- Package cart_ram_pkg:
  - state enum {IDLE, BUSY, BK_HI}
  - source enum {SRC_MAP, SRC_CPU, SRC_BK}
  - request struct {valid, we, addr, data}
  - reset constants 8'hFF and 16'hFFFF
- Sub-module cart_ram_slot: one pending slot with capture/overwrite/clear logic and an overrun flag. Instantiated three times.

Test Plan:
- CPU read: cpu_rd with cpu_addr=17'h00123 and memory returning 8'h5A after 3 cycles -> mem_req 2 cycles after the strobe with mem_we=0 and mem_addr=17'h00123; cpu_do=8'h5A the cycle after ack; cpu_busy then low.
- Simultaneous strobes: map_wr (addr 17'h00010, data 8'hAA) and cpu_wr (addr 17'h00020, data 8'h55) in the same cycle -> map write issued first, CPU write second, 1-cycle mem_req gap.
- Backup word atomicity: bk_wr word addr 16'h0004 with data 16'hBEEF, then map_wr during byte 0 -> mem writes 17'h00008=EF and 17'h00009=BE consecutively, bk_ack pulses, then the map write issues.
- Overrun: two cpu_wr strobes 1 cycle apart while a map write is in flight -> only the second CPU write reaches memory; overrun=1.
- Reset during BUSY -> mem_req=0 immediately; cpu_do=8'hFF; no later spurious request.
- Timeout with CART_RAM_TIMEOUT_EN, TIMEOUT=64, cpu_rd and no ack -> cpu_do=8'hFF after 64 cycles; timeout_err=1.
